// File: rtl/fft_axi_burst_slave_if.sv
// AXI4 burst channel bundle between the interconnect (master) and the FFT sample RAM slave.
interface fft_axi_burst_slave_if #(
   parameter int SAMPLE_W = 16,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int ID_W     = 2
);
   logic [ADDR_W-1:0]     AWADDR;
   logic [7:0]            AWLEN;
   logic [2:0]            AWSIZE;
   logic [1:0]            AWBURST;
   logic [ID_W-1:0]       AWID;
   logic                  AWVALID;
   logic                  AWREADY;

   logic [ADDR_W-1:0]     ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [1:0]            ARBURST;
   logic [ID_W-1:0]       ARID;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [SAMPLE_W-1:0]   WDATA;
   logic [SAMPLE_W/8-1:0] WSTRB;
   logic                  WLAST;
   logic                  WVALID;
   logic                  WREADY;

   logic                  BVALID;
   logic [ID_W-1:0]       BID;
   logic [1:0]            BRESP;
   logic                  BREADY;

   logic [DATA_W-1:0]     RDATA;
   logic [ID_W-1:0]       RID;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport slave (
      input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
      input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
      input  WDATA, WSTRB, WLAST, WVALID, BREADY, RREADY,
      output AWREADY, ARREADY, WREADY, BVALID, BID, BRESP,
      output RDATA, RID, RRESP, RLAST, RVALID
   );

   modport master (
      output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
      output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
      output WDATA, WSTRB, WLAST, WVALID, BREADY, RREADY,
      input  AWREADY, ARREADY, WREADY, BVALID, BID, BRESP,
      input  RDATA, RID, RRESP, RLAST, RVALID
   );
endinterface

// File: rtl/fft_axi_burst_slave.sv
// AXI4 burst slave loading/unloading the FFT sample RAM (FIXED/INCR/WRAP, SLVERR on illegal bursts).
// Latency: W beat writes RAM in its handshake cycle; R beat every 2 cycles (RAM read, then RVALID).
// Backpressure: B and R held stable until BREADY/RREADY; no new address accepted outside IDLE.
module fft_axi_burst_slave #(
   parameter int SAMPLE_W = 16,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int ID_W     = 2
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   fft_axi_burst_slave_if.slave axi,
   output logic                o_ram_we,
   output logic                o_ram_re,
   output logic [ADDR_W-1:0]   o_ram_idx,
   output logic [SAMPLE_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0]   i_ram_rdata,
   input  logic                i_calc_end,
   output logic                o_data_loaded
);
   localparam int W_MAX = $clog2(SAMPLE_W/8);
   localparam int R_MAX = $clog2(DATA_W/8);

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RREQ, S_RDATA} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [7:0]          len_q, beat_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [ID_W-1:0]     id_q;
   logic                err_q, rd_first;
   logic [DATA_W-1:0]   rdata_q, rd_fresh;

   function automatic logic req_err(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst, input int max_size);
      logic wrap_bad, unaligned;
      wrap_bad  = (burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      unaligned = ((32'(a) & ((32'd1 << size) - 32'd1)) != 32'd0);
      return (burst == 2'b11) || wrap_bad || (int'(size) > max_size) || unaligned;
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                   input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] step, mask, sum;
      step = 32'd1 << size;
      mask = ((32'(len) + 32'd1) << size) - 32'd1;
      case (burst)
         2'b01:   sum = 32'(a) + step;
         2'b10:   sum = (32'(a) & ~mask) | ((32'(a) + step) & mask);
         default: sum = 32'(a);
      endcase
      return sum[ADDR_W-1:0];
   endfunction

   // Handshakes are decoded from state and inputs only, so no combinational loop via the READY outputs.
   wire aw_hs     = (state_q == S_IDLE) && axi.AWVALID;
   wire ar_hs     = (state_q == S_IDLE) && axi.ARVALID && i_calc_end && !axi.AWVALID;
   wire w_hs      = (state_q == S_WDATA) && axi.WVALID;
   wire b_hs      = (state_q == S_WRESP) && axi.BREADY;
   wire r_hs      = (state_q == S_RDATA) && axi.RREADY;
   wire last_beat = (beat_q == len_q);
   wire wlast_bad = w_hs && (axi.WLAST != last_beat);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (aw_hs) state_d = S_WDATA;
                  else if (ar_hs) state_d = S_RREQ;
         S_WDATA: if (w_hs && last_beat) state_d = S_WRESP;
         S_WRESP: if (b_hs) state_d = S_IDLE;
         S_RREQ:  state_d = S_RDATA;
         S_RDATA: if (r_hs) state_d = last_beat ? S_IDLE : S_RREQ;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         addr_q   <= '0;
         len_q    <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         beat_q   <= '0;
         rdata_q  <= '0;
         rd_first <= 1'b0;
      end else begin
         rd_first <= (state_q == S_RREQ);
         if (aw_hs) begin
            addr_q  <= axi.AWADDR;
            len_q   <= axi.AWLEN;
            size_q  <= axi.AWSIZE;
            burst_q <= axi.AWBURST;
            id_q    <= axi.AWID;
            err_q   <= req_err(axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST, W_MAX);
            beat_q  <= '0;
         end else if (ar_hs) begin
            addr_q  <= axi.ARADDR;
            len_q   <= axi.ARLEN;
            size_q  <= axi.ARSIZE;
            burst_q <= axi.ARBURST;
            id_q    <= axi.ARID;
            err_q   <= req_err(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST, R_MAX);
            beat_q  <= '0;
         end else if (w_hs) begin
            err_q  <= err_q | wlast_bad;
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
         end else if (r_hs && !last_beat) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr(addr_q, len_q, size_q, burst_q);
         end
         if (rd_first) rdata_q <= rd_fresh;
      end
   end

   // RAM data arrives in the first RDATA cycle: forward it then, hold the captured copy while stalled.
   assign rd_fresh = err_q ? '0 : i_ram_rdata;

   always_comb begin
      axi.AWREADY   = (state_q == S_IDLE) && i_rstn;
      axi.ARREADY   = (state_q == S_IDLE) && i_rstn && i_calc_end && !axi.AWVALID;
      axi.WREADY    = 1'b0;
      axi.BVALID    = 1'b0;
      axi.BID       = '0;
      axi.BRESP     = 2'b00;
      axi.RVALID    = 1'b0;
      axi.RID       = '0;
      axi.RRESP     = 2'b00;
      axi.RLAST     = 1'b0;
      axi.RDATA     = rd_first ? rd_fresh : rdata_q;
      o_ram_we      = 1'b0;
      o_ram_re      = 1'b0;
      o_ram_idx     = '0;
      o_ram_wdata   = '0;
      o_data_loaded = 1'b0;
      case (state_q)
         S_WDATA: begin
            axi.WREADY  = 1'b1;
            o_ram_idx   = addr_q >> size_q;
            o_ram_wdata = axi.WDATA;
            o_ram_we    = w_hs && !err_q && !wlast_bad && (&axi.WSTRB);
         end
         S_WRESP: begin
            axi.BVALID    = 1'b1;
            axi.BID       = id_q;
            axi.BRESP     = err_q ? 2'b10 : 2'b00;
            o_data_loaded = axi.BREADY && !err_q;
         end
         S_RREQ: begin
            o_ram_idx = addr_q >> size_q;
            o_ram_re  = !err_q;
         end
         S_RDATA: begin
            axi.RVALID = 1'b1;
            axi.RID    = id_q;
            axi.RRESP  = err_q ? 2'b10 : 2'b00;
            axi.RLAST  = last_beat;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_fft_axi_burst_slave.sv
// Directed bench for fft_axi_burst_slave: bursts, stalls, arbitration, error responses, mid-burst reset.
module tb_fft_axi_burst_slave;
   localparam int SAMPLE_W = 16;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 12;
   localparam int ID_W     = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic                ram_we, ram_re, calc_end, data_loaded;
   logic [ADDR_W-1:0]   ram_idx;
   logic [SAMPLE_W-1:0] ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   fft_axi_burst_slave_if #(.SAMPLE_W(SAMPLE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

   fft_axi_burst_slave #(.SAMPLE_W(SAMPLE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
      .i_clk(clk), .i_rstn(rstn), .axi(bus),
      .o_ram_we(ram_we), .o_ram_re(ram_re), .o_ram_idx(ram_idx), .o_ram_wdata(ram_wdata),
      .i_ram_rdata(ram_rdata), .i_calc_end(calc_end), .o_data_loaded(data_loaded)
   );

   int errors = 0;
   int checks = 0;
   int we_idx[$];
   int we_dat[$];
   int re_idx[$];
   int loaded_cnt = 0;

   // Sample RAM: registered read, word content derived from its index.
   always @(posedge clk or negedge rstn) begin
      if (!rstn)       ram_rdata <= '0;
      else if (ram_re) ram_rdata <= 32'hD000_0000 | 32'(ram_idx);
   end

   always @(posedge clk) begin
      if (ram_we) begin
         we_idx.push_back(int'(ram_idx));
         we_dat.push_back(int'(ram_wdata));
      end
      if (ram_re) re_idx.push_back(int'(ram_idx));
      if (data_loaded) loaded_cnt++;
   end

   task automatic aw_send(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [1:0] id, output bit ok);
      bus.AWADDR = a; bus.AWLEN = l; bus.AWSIZE = s; bus.AWBURST = b; bus.AWID = id; bus.AWVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.AWREADY) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.AWVALID = 1'b0;
   endtask

   task automatic ar_send(input logic [11:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [1:0] id, output bit ok);
      bus.ARADDR = a; bus.ARLEN = l; bus.ARSIZE = s; bus.ARBURST = b; bus.ARID = id; bus.ARVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ARREADY) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.ARVALID = 1'b0;
   endtask

   task automatic w_send(input logic [15:0] d, input logic [1:0] strb, input logic last, output bit ok);
      bus.WDATA = d; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.WREADY) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.WVALID = 1'b0; bus.WLAST = 1'b0;
   endtask

   task automatic b_wait(output bit ok, output logic [1:0] resp, output logic [1:0] id, output logic ld);
      ok = 1'b0; resp = 2'bxx; id = 2'bxx; ld = 1'bx;
      for (int i = 0; i < 30; i++) begin
         if (bus.BVALID) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         resp = bus.BRESP; id = bus.BID;
         bus.BREADY = 1'b1;
         #1 ld = data_loaded;
         @(posedge clk); #1 bus.BREADY = 1'b0;
      end
   endtask

   task automatic r_recv(input int stall, output bit ok, output logic [31:0] d, output logic last,
                         output logic [1:0] resp, output logic [1:0] id, output bit stable);
      ok = 1'b0; stable = 1'b1; d = 'x; last = 1'bx; resp = 2'bxx; id = 2'bxx;
      for (int i = 0; i < 30; i++) begin
         if (bus.RVALID) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin
         d = bus.RDATA; last = bus.RLAST; resp = bus.RRESP; id = bus.RID;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (bus.RVALID !== 1'b1 || bus.RDATA !== d || bus.RLAST !== last) stable = 1'b0;
         end
         bus.RREADY = 1'b1;
         @(posedge clk); #1 bus.RREADY = 1'b0;
      end
   endtask

   task automatic test_reset();
      bus.AWVALID = 0; bus.ARVALID = 0; bus.WVALID = 0; bus.WLAST = 0; bus.BREADY = 0; bus.RREADY = 0;
      bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0; bus.AWID = 0;
      bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0; bus.ARID = 0;
      bus.WDATA = 0; bus.WSTRB = 0; calc_end = 0;
      repeat (2) @(negedge clk);
      checks++; if (bus.AWREADY !== 1'b0) begin errors++; $display("FAIL reset_awready_in_reset: got %b want 0", bus.AWREADY); end
      rstn = 1'b1;
      #1;
      checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", bus.AWREADY); end
      checks++;
      if ({bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST, ram_we, ram_re, data_loaded} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000000",
            {bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID, bus.RLAST, ram_we, ram_re, data_loaded});
      end
      checks++;
      if ({bus.RDATA, bus.BID, bus.RID, ram_idx} !== '0) begin
         errors++; $display("FAIL reset_data: got %h want 0", {bus.RDATA, bus.BID, bus.RID, ram_idx});
      end
   endtask

   task automatic test_incr_write();
      bit ok; logic [1:0] resp, id; logic ld; int bad = 0;
      we_idx.delete(); we_dat.delete(); loaded_cnt = 0;
      aw_send(12'h000, 8'd3, 3'd1, 2'b01, 2'd2, ok); if (!ok) bad++;
      for (int i = 0; i < 4; i++) begin w_send(16'(i + 1), 2'b11, i == 3, ok); if (!ok) bad++; end
      b_wait(ok, resp, id, ld); if (!ok) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL incr_handshakes: got %0d missing want 0", bad); end
      checks++; if (we_idx.size() !== 4) begin errors++; $display("FAIL incr_we_count: got %0d want 4", we_idx.size()); end
      for (int i = 0; i < 4 && i < we_idx.size(); i++) begin
         checks++;
         if (we_idx[i] != i || we_dat[i] != i + 1) begin
            errors++; $display("FAIL incr_we_%0d: got idx %0d data %0d want idx %0d data %0d", i, we_idx[i], we_dat[i], i, i + 1);
         end
      end
      checks++; if ({resp, id} !== {2'b00, 2'd2}) begin errors++; $display("FAIL incr_bresp_bid: got %b want 0010", {resp, id}); end
      checks++; if (ld !== 1'b1 || loaded_cnt !== 1) begin errors++; $display("FAIL incr_loaded: got %b/%0d want 1/1", ld, loaded_cnt); end
   endtask

   task automatic test_wrap_read();
      bit ok, st; logic [31:0] d; logic last; logic [1:0] resp, id;
      int exp_idx[4] = '{3, 0, 1, 2};
      re_idx.delete(); calc_end = 1'b1;
      ar_send(12'h00C, 8'd3, 3'd2, 2'b10, 2'd1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_ar_hs: got 0 want 1"); end
      for (int k = 0; k < 4; k++) begin
         r_recv(k == 1 ? 3 : 0, ok, d, last, resp, id, st);
         checks++;
         if (!ok || d !== (32'hD000_0000 | 32'(exp_idx[k])) || last !== (k == 3) || {resp, id} !== 4'b0001) begin
            errors++; $display("FAIL wrap_beat_%0d: got ok %b data %h last %b resp/id %b want data %h last %b resp/id 0001",
               k, ok, d, last, {resp, id}, 32'hD000_0000 | 32'(exp_idx[k]), k == 3);
         end
         if (k == 1) begin
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL wrap_stall_stable: got %b want 1", st); end
         end
      end
      checks++;
      if (re_idx.size() !== 4 || re_idx[0] != 3 || re_idx[1] != 0 || re_idx[2] != 1 || re_idx[3] != 2) begin
         errors++; $display("FAIL wrap_re_idx: got %p want 3 0 1 2", re_idx);
      end
   endtask

   task automatic test_calc_end_gate();
      bit ok, st; logic [31:0] d; logic last; logic [1:0] resp, id; int seen = 0;
      calc_end = 1'b0;
      bus.ARADDR = 12'h008; bus.ARLEN = 0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARID = 2'd3; bus.ARVALID = 1'b1;
      repeat (3) begin @(negedge clk); if (bus.ARREADY) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL gate_arready_low: got %0d cycles high want 0", seen); end
      calc_end = 1'b1;
      #1;
      checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL gate_arready_rise: got %b want 1", bus.ARREADY); end
      @(posedge clk); #1 bus.ARVALID = 1'b0;
      r_recv(0, ok, d, last, resp, id, st);
      checks++;
      if (!ok || d !== 32'hD000_0002 || last !== 1'b1 || {resp, id} !== 4'b0011) begin
         errors++; $display("FAIL gate_rbeat: got ok %b data %h last %b resp/id %b want data d0000002 last 1 resp/id 0011", ok, d, last, {resp, id});
      end
   endtask

   task automatic test_aw_ar_priority();
      bit ok, st; logic [31:0] d; logic last; logic [1:0] resp, id; logic ld; logic ar_mid;
      we_idx.delete(); we_dat.delete(); calc_end = 1'b1;
      @(negedge clk);
      bus.AWADDR = 12'h004; bus.AWLEN = 0; bus.AWSIZE = 3'd1; bus.AWBURST = 2'b01; bus.AWID = 2'd0; bus.AWVALID = 1'b1;
      bus.ARADDR = 12'h004; bus.ARLEN = 0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARID = 2'd2; bus.ARVALID = 1'b1;
      #1;
      checks++; if ({bus.AWREADY, bus.ARREADY} !== 2'b10) begin errors++; $display("FAIL prio_ready: got %b want 10", {bus.AWREADY, bus.ARREADY}); end
      @(posedge clk); #1 bus.AWVALID = 1'b0;
      w_send(16'h1234, 2'b11, 1'b1, ok);
      ar_mid = bus.ARREADY;
      b_wait(ok, resp, id, ld);
      checks++; if (ar_mid !== 1'b0) begin errors++; $display("FAIL prio_ar_during_wresp: got %b want 0", ar_mid); end
      checks++;
      if (!ok || {resp, id} !== 4'b0000 || we_idx.size() !== 1 || we_idx[0] != 2 || we_dat[0] != 16'h1234) begin
         errors++; $display("FAIL prio_write: got ok %b resp/id %b writes %0d want ok 1 resp/id 0000 one write idx 2", ok, {resp, id}, we_idx.size());
      end
      checks++; if (bus.ARREADY !== 1'b1) begin errors++; $display("FAIL prio_ar_after_b: got %b want 1", bus.ARREADY); end
      @(posedge clk); #1 bus.ARVALID = 1'b0;
      r_recv(0, ok, d, last, resp, id, st);
      checks++;
      if (!ok || d !== 32'hD000_0001 || last !== 1'b1 || {resp, id} !== 4'b0010) begin
         errors++; $display("FAIL prio_read: got ok %b data %h last %b resp/id %b want data d0000001 last 1 resp/id 0010", ok, d, last, {resp, id});
      end
   endtask

   task automatic test_errors();
      bit ok, st; logic [31:0] d; logic last; logic [1:0] resp, id; logic ld; int bad = 0;
      we_idx.delete(); re_idx.delete(); loaded_cnt = 0; calc_end = 1'b1;
      aw_send(12'h000, 8'd2, 3'd1, 2'b11, 2'd1, ok); if (!ok) bad++;
      for (int i = 0; i < 3; i++) begin w_send(16'hAA00 + 16'(i), 2'b11, i == 2, ok); if (!ok) bad++; end
      b_wait(ok, resp, id, ld); if (!ok) bad++;
      checks++; if ({resp, id, ld} !== 5'b10010) begin errors++; $display("FAIL err_burst11_b: got resp/id/ld %b want 10010", {resp, id, ld}); end
      aw_send(12'h000, 8'd3, 3'd1, 2'b01, 2'd2, ok); if (!ok) bad++;
      for (int i = 0; i < 4; i++) begin w_send(16'hBB00 + 16'(i), 2'b11, i == 0 || i == 3, ok); if (!ok) bad++; end
      b_wait(ok, resp, id, ld); if (!ok) bad++;
      checks++; if ({resp, id, ld} !== 5'b10100) begin errors++; $display("FAIL err_early_wlast_b: got resp/id/ld %b want 10100", {resp, id, ld}); end
      ar_send(12'h000, 8'd1, 3'd3, 2'b01, 2'd0, ok); if (!ok) bad++;
      for (int k = 0; k < 2; k++) begin
         r_recv(0, ok, d, last, resp, id, st);
         checks++;
         if (!ok || d !== 32'h0 || last !== (k == 1) || {resp, id} !== 4'b1000) begin
            errors++; $display("FAIL err_size3_beat_%0d: got ok %b data %h last %b resp/id %b want data 0 last %b resp/id 1000", k, ok, d, last, {resp, id}, k == 1);
         end
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL err_handshakes: got %0d missing want 0", bad); end
      checks++;
      if (we_idx.size() !== 0 || re_idx.size() !== 0 || loaded_cnt !== 0) begin
         errors++; $display("FAIL err_no_ram_access: got we %0d re %0d loaded %0d want 0 0 0", we_idx.size(), re_idx.size(), loaded_cnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok; logic [1:0] resp, id; logic ld; int bvalid_seen = 0;
      aw_send(12'h010, 8'd7, 3'd1, 2'b01, 2'd3, ok);
      w_send(16'h0101, 2'b11, 1'b0, ok);
      w_send(16'h0202, 2'b11, 1'b0, ok);
      bus.WDATA = 16'h0303; bus.WSTRB = 2'b11; bus.WVALID = 1'b1;
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if ({bus.AWREADY, bus.WREADY, bus.BVALID, ram_we, ram_wdata, ram_idx} !== '0) begin
         errors++; $display("FAIL midrst_outputs: got %h want 0", {bus.AWREADY, bus.WREADY, bus.BVALID, ram_we, ram_wdata, ram_idx});
      end
      bus.WVALID = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (5) begin @(negedge clk); if (bus.BVALID) bvalid_seen++; end
      checks++; if (bvalid_seen !== 0) begin errors++; $display("FAIL midrst_no_b: got %0d cycles BVALID want 0", bvalid_seen); end
      we_idx.delete(); we_dat.delete(); loaded_cnt = 0;
      aw_send(12'h002, 8'd0, 3'd1, 2'b01, 2'd1, ok);
      w_send(16'h55AA, 2'b11, 1'b1, ok);
      b_wait(ok, resp, id, ld);
      checks++;
      if (!ok || {resp, id, ld} !== 5'b00011 || we_idx.size() !== 1 || we_idx[0] != 1 || we_dat[0] != 16'h55AA) begin
         errors++; $display("FAIL midrst_next_write: got ok %b resp/id/ld %b writes %0d want ok 1 resp/id/ld 00011 one write idx 1 data 55aa",
            ok, {resp, id, ld}, we_idx.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_incr_write();
      test_wrap_read();
      test_calc_end_gate();
      test_aw_ar_priority();
      test_errors();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
